// File: rtl/flag_pipe_unit.sv
// ALU flag pipeline: per-op {N,Z,C,V} through a one-entry valid/ready stage plus architectural NZCV.
// Optional sticky C/V accumulation when STICKY_FLAGS_EN is defined.
module flag_pipe_unit #(
  parameter int W = 4,
  parameter int OP_W = 4,
  parameter logic [OP_W-1:0] ADD_OP = OP_W'(0),
  parameter logic [OP_W-1:0] SUB_OP = OP_W'(1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] opcode,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    op_result,
  input  logic            add_cout,
  input  logic            sub_cout,
  input  logic            flag_we,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_flags,
  output logic [3:0]      arch_flags,
  input  logic            clr_sticky,
  output logic [1:0]      sticky_cv
);

  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic [3:0] flags;
  logic       transfer;
  logic       arch_wr;

  assign flag_n = op_result[W-1];
  assign flag_z = (op_result == '0);

  // Signed overflow: operand signs relate as the op requires and result sign flips away from a.
  always_comb begin
    flag_c = 1'b0;
    flag_v = 1'b0;
    if (opcode == ADD_OP) begin
      flag_c = add_cout;
      flag_v = (a[W-1] == b[W-1]) && (op_result[W-1] != a[W-1]);
    end else if (opcode == SUB_OP) begin
      flag_c = sub_cout;
      flag_v = (a[W-1] != b[W-1]) && (op_result[W-1] != a[W-1]);
    end
  end

  assign flags    = {flag_n, flag_z, flag_c, flag_v};
  assign in_ready = !out_valid || out_ready;
  assign transfer = in_valid && in_ready;
  assign arch_wr  = transfer && flag_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_flags  <= 4'b0000;
      arch_flags <= 4'b0000;
    end else begin
      if (transfer) begin
        out_valid <= 1'b1;
        out_flags <= flags;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (arch_wr) arch_flags <= flags;
    end
  end

`ifdef STICKY_FLAGS_EN
  // A setting write in the same cycle as a clear leaves only the new {C,V}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_cv <= 2'b00;
    end else if (arch_wr) begin
      sticky_cv <= clr_sticky ? {flag_c, flag_v} : (sticky_cv | {flag_c, flag_v});
    end else if (clr_sticky) begin
      sticky_cv <= 2'b00;
    end
  end
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign sticky_cv = 2'b00;
`endif

endmodule
